// File: rtl/bus_fifo_port.sv
// Memory-mapped byte FIFO port on the 6502 bus: a TX FIFO (CPU to device) and
// an RX FIFO (device to CPU) behind a 4-byte register window.
`timescale 1ns/1ps

module bus_fifo_port #(
    parameter logic [15:0] BASE_ADDR = 16'hD000,
    parameter int          DEPTH     = 8
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        read_en,
    input  logic        bus_valid,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
    ,output logic       irq
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    // Handshake: a byte moves on a rising edge where valid and ready are both 1;
    // the sender holds data stable until then, and ready never depends on valid.

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [3:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, rx_stall_q, rx_stall_d;
    logic [1:0]    ctrl_q, ctrl_d;

    logic       sel, rd, wr;
    logic [1:0] off;
    logic       data_rd, data_wr, stat_wr, ctrl_wr;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] status;

    assign sel     = bus_valid && (address[15:2] == BASE_ADDR[15:2]);
    assign off     = address[1:0];
    assign rd      = sel & read_en;
    assign wr      = sel & ~read_en;
    assign data_oe = rd;

    assign data_rd = rd && (off == 2'd0);
    assign data_wr = wr && (off == 2'd0);
    assign stat_wr = wr && (off == 2'd1);
    assign ctrl_wr = wr && (off == 2'd2);

    assign tx_empty = (tx_cnt_q == 4'd0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == 4'd0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    // Gated by reset so no device transfer can complete while held in reset.
    assign tx_valid = reset & ~tx_empty;
    assign rx_ready = reset & ~rx_full;
    assign tx_data  = tx_mem_q[tx_rp_q];

    assign tx_push = data_wr & ~tx_full;
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = data_rd & ~rx_empty;

    assign irq = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | tx_ovf_q | rx_unf_q;

    assign status = {irq, rx_unf_q, rx_stall_q, tx_ovf_q,
                     tx_empty, rx_full, ~tx_full, ~rx_empty};

    always_comb begin
        tx_wp_d    = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
        tx_rp_d    = tx_pop  ? tx_rp_q + AW'(1) : tx_rp_q;
        rx_wp_d    = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
        rx_rp_d    = rx_pop  ? rx_rp_q + AW'(1) : rx_rp_q;
        tx_cnt_d   = tx_cnt_q + {3'b000, tx_push} - {3'b000, tx_pop};
        rx_cnt_d   = rx_cnt_q + {3'b000, rx_push} - {3'b000, rx_pop};
        // Sticky flags: a set in the same cycle as a W1C clear wins.
        tx_ovf_d   = (data_wr & tx_full)  | (tx_ovf_q   & ~(stat_wr & data_in[4]));
        rx_stall_d = (rx_valid & rx_full) | (rx_stall_q & ~(stat_wr & data_in[5]));
        rx_unf_d   = (data_rd & rx_empty) | (rx_unf_q   & ~(stat_wr & data_in[6]));
        ctrl_d     = ctrl_wr ? data_in[1:0] : ctrl_q;
    end

    always_comb begin
        data_out = 8'h00;
        if (rd) begin
            case (off)
                2'd0:    data_out = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
                2'd1:    data_out = status;
                2'd2:    data_out = {6'b000000, ctrl_q};
                default: data_out = {tx_cnt_q, rx_cnt_q};
            endcase
        end
    end

    always_ff @(posedge ph2) begin
        if (!reset) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            rx_stall_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            rx_stall_q <= rx_stall_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge ph2) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= data_in;
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed bench for bus_fifo_port: register map, both FIFOs, sticky flags,
// simultaneous events and reset, checked against hand-computed values.
`timescale 1ns/1ps

module tb_bus_fifo_port;

    localparam logic [15:0] A_DATA  = 16'hD000;
    localparam logic [15:0] A_STAT  = 16'hD001;
    localparam logic [15:0] A_CTRL  = 16'hD002;
    localparam logic [15:0] A_COUNT = 16'hD003;

    logic        ph2 = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        read_en;
    logic        bus_valid;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_d;
    logic       rd_oe;

    bus_fifo_port #(.BASE_ADDR(16'hD000), .DEPTH(8)) dut (
        .ph2(ph2), .reset(reset), .address(address), .read_en(read_en),
        .bus_valid(bus_valid), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    // Clock
    always #5 ph2 = ~ph2;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Drivers: every task starts and ends 1 ns after a rising edge.
    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] d, output logic oe);
        address = addr; read_en = 1'b1; bus_valid = 1'b1;
        @(negedge ph2);
        d  = data_out;
        oe = data_oe;
        @(posedge ph2); #1;
        bus_valid = 1'b0; address = 16'h0000;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        cpu_read(addr, d, oe);
        check(tag, d, exp);
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
        address = addr; read_en = 1'b0; data_in = d; bus_valid = 1'b1;
        @(posedge ph2); #1;
        bus_valid = 1'b0; read_en = 1'b1; address = 16'h0000;
    endtask

    task automatic dev_push(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge ph2); #1;
        rx_valid = 1'b0;
    endtask

    // Drain TX against exp_q; extra cycles catch bytes that should not exist.
    task automatic drain_tx(input int max_cycles);
        tx_ready = 1'b1;
        repeat (max_cycles) begin
            @(negedge ph2);
            if (tx_valid) begin
                if (exp_q.size() == 0) check("tx_extra_valid", {7'b0, tx_valid}, 8'h00);
                else                   check("tx_data", tx_data, exp_q.pop_front());
            end
            @(posedge ph2); #1;
        end
        tx_ready = 1'b0;
        check("tx_left", 8'(exp_q.size()), 8'h00);
        exp_q.delete();
    endtask

    task automatic drain_rx(input int n);
        repeat (n) rd_check("rx_data", A_DATA, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b0; address = 16'h0000; read_en = 1'b1; bus_valid = 1'b0;
        data_in = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        // Reset and idle
        @(posedge ph2); #1;
        @(negedge ph2);
        check("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        @(posedge ph2); #1;
        reset = 1'b1;
        @(negedge ph2);
        check("idle_rx_ready", {7'b0, rx_ready}, 8'h01);
        check("idle_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("idle_irq", {7'b0, irq}, 8'h00);
        check("idle_oe", {7'b0, data_oe}, 8'h00);
        check("idle_dout", data_out, 8'h00);
        @(posedge ph2); #1;
        rd_check("idle_status", A_STAT, 8'h0A);
        rd_check("idle_count", A_COUNT, 8'h00);
        cpu_read(16'hD004, rd_d, rd_oe);
        check("miss_oe", {7'b0, rd_oe}, 8'h00);
        check("miss_dout", rd_d, 8'h00);

        // TX fill and overflow
        for (int i = 0; i < 8; i++) begin
            cpu_write(A_DATA, 8'h11 + 8'(i));
            exp_q.push_back(8'h11 + 8'(i));
        end
        cpu_write(A_DATA, 8'h99);
        rd_check("txfull_count", A_COUNT, 8'h80);
        rd_check("txfull_status", A_STAT, 8'h90);
        drain_tx(12);
        rd_check("txovf_status", A_STAT, 8'h9A);
        cpu_write(A_STAT, 8'h10);
        rd_check("txovf_clr", A_STAT, 8'h0A);

        // RX stream and underflow
        dev_push(8'hA5);
        dev_push(8'h5A);
        rd_check("rx2_count", A_COUNT, 8'h02);
        rd_check("rx_rd0", A_DATA, 8'hA5);
        rd_check("rx_rd1", A_DATA, 8'h5A);
        rd_check("rx_unf_rd", A_DATA, 8'h00);
        rd_check("rxunf_status", A_STAT, 8'hCA);
        @(negedge ph2);
        check("rxunf_irq", {7'b0, irq}, 8'h01);
        @(posedge ph2); #1;
        cpu_write(A_STAT, 8'h40);
        rd_check("rxunf_clr", A_STAT, 8'h0A);

        // RX full backpressure
        for (int i = 0; i < 8; i++) dev_push(8'h30 + 8'(i));
        @(negedge ph2);
        check("rxfull_ready", {7'b0, rx_ready}, 8'h00);
        @(posedge ph2); #1;
        rd_check("rxfull_status", A_STAT, 8'h0F);
        rx_data = 8'h38; rx_valid = 1'b1;
        @(posedge ph2); #1;
        rd_check("rxstall_status", A_STAT, 8'h2F);
        rd_check("rxfull_pop", A_DATA, 8'h30);
        @(negedge ph2);
        check("rxpop_ready", {7'b0, rx_ready}, 8'h01);
        @(posedge ph2); #1;
        rx_valid = 1'b0;
        rd_check("rxrefill_count", A_COUNT, 8'h08);
        for (int i = 1; i < 9; i++) exp_q.push_back(8'h30 + 8'(i));
        drain_rx(8);
        rd_check("rxstall_hold", A_STAT, 8'h2A);
        cpu_write(A_STAT, 8'h20);
        rd_check("rxstall_clr", A_STAT, 8'h0A);

        // Simultaneous TX push and pop, not full
        cpu_write(A_DATA, 8'h41);
        cpu_write(A_DATA, 8'h42);
        cpu_write(A_DATA, 8'h43);
        rd_check("tx3_count", A_COUNT, 8'h30);
        tx_ready = 1'b1;
        cpu_write(A_DATA, 8'h44);
        tx_ready = 1'b0;
        rd_check("txsim_count", A_COUNT, 8'h30);
        exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
        drain_tx(6);

        // Simultaneous TX push and pop while full: push dropped, pop occurs
        for (int i = 0; i < 8; i++) cpu_write(A_DATA, 8'h50 + 8'(i));
        tx_ready = 1'b1;
        cpu_write(A_DATA, 8'h58);
        tx_ready = 1'b0;
        rd_check("txfullsim_count", A_COUNT, 8'h70);
        rd_check("txfullsim_status", A_STAT, 8'h92);
        for (int i = 1; i < 8; i++) exp_q.push_back(8'h50 + 8'(i));
        drain_tx(10);
        cpu_write(A_STAT, 8'h10);

        // Interrupt enable, then reset mid-stream
        cpu_write(A_CTRL, 8'h02);
        rd_check("ctrl_rd", A_CTRL, 8'h02);
        @(negedge ph2);
        check("txie_irq", {7'b0, irq}, 8'h01);
        @(posedge ph2); #1;
        cpu_write(A_DATA, 8'h77);
        @(negedge ph2);
        check("pre_rst_tx_valid", {7'b0, tx_valid}, 8'h01);
        @(posedge ph2); #1;
        reset = 1'b0;
        @(negedge ph2);
        check("inrst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("inrst_rx_ready", {7'b0, rx_ready}, 8'h00);
        @(posedge ph2); #1;
        reset = 1'b1;
        @(negedge ph2);
        check("postrst_irq", {7'b0, irq}, 8'h00);
        check("postrst_tx_valid", {7'b0, tx_valid}, 8'h00);
        @(posedge ph2); #1;
        rd_check("postrst_ctrl", A_CTRL, 8'h00);
        rd_check("postrst_count", A_COUNT, 8'h00);
        drain_tx(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
